// File: rtl/imuldiv_muldiv_dispatch_pkg.sv
// Shared encodings for the muldiv dispatch stage: function codes, field widths, FSM states.
// Also holds the decode helpers used by both the control FSM and the datapath.
package imuldiv_muldiv_dispatch_pkg;

    localparam int unsigned FN_W     = 3;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned RESULT_W = 64;

    localparam logic [FN_W-1:0] IMULDIV_MULDIVREQ_MSG_FUNC_MUL  = 3'd0;
    localparam logic [FN_W-1:0] IMULDIV_MULDIVREQ_MSG_FUNC_DIV  = 3'd1;
    localparam logic [FN_W-1:0] IMULDIV_MULDIVREQ_MSG_FUNC_DIVU = 3'd2;
    localparam logic [FN_W-1:0] IMULDIV_MULDIVREQ_MSG_FUNC_REM  = 3'd3;
    localparam logic [FN_W-1:0] IMULDIV_MULDIVREQ_MSG_FUNC_REMU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dispatch_state_e;

    typedef enum logic [1:0] {
        UNIT_NONE = 2'd0,
        UNIT_MUL  = 2'd1,
        UNIT_DIV  = 2'd2
    } unit_e;

    typedef enum logic [1:0] {
        RSEL_ZERO    = 2'd0,
        RSEL_MUL     = 2'd1,
        RSEL_DIV     = 2'd2,
        RSEL_DIVZERO = 2'd3
    } result_sel_e;

    function automatic unit_e fn_unit(input logic [FN_W-1:0] fn);
        unit_e u;
        case (fn)
            IMULDIV_MULDIVREQ_MSG_FUNC_MUL:  u = UNIT_MUL;
            IMULDIV_MULDIVREQ_MSG_FUNC_DIV,
            IMULDIV_MULDIVREQ_MSG_FUNC_DIVU,
            IMULDIV_MULDIVREQ_MSG_FUNC_REM,
            IMULDIV_MULDIVREQ_MSG_FUNC_REMU: u = UNIT_DIV;
            default:                         u = UNIT_NONE;
        endcase
        return u;
    endfunction

    function automatic logic fn_is_signed(input logic [FN_W-1:0] fn);
        return (fn == IMULDIV_MULDIVREQ_MSG_FUNC_DIV) || (fn == IMULDIV_MULDIVREQ_MSG_FUNC_REM);
    endfunction

endpackage

// File: rtl/imuldiv_muldiv_dispatch_ctrl.sv
// Dispatch FSM: sequences IDLE/ISSUE/WAIT/RESP and produces registered val/rdy for all ports.
// Outputs are decoded from the next state so every handshake signal leaves a flop.
module imuldiv_muldiv_dispatch_ctrl
    import imuldiv_muldiv_dispatch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_val,
    input  logic [FN_W-1:0]   req_fn,
    input  logic              req_b_zero,
    input  logic [FN_W-1:0]   cur_fn,
    input  logic              cur_b_zero,
    input  logic              mul_req_rdy,
    input  logic              div_req_rdy,
    input  logic              mul_resp_val,
    input  logic              div_resp_val,
    input  logic              resp_rdy,
    output logic              req_rdy,
    output logic              resp_val,
    output logic              mul_req_val,
    output logic              div_req_val,
    output logic              mul_resp_rdy,
    output logic              div_resp_rdy,
    output logic              accept,
    output logic              load_result,
    output result_sel_e       result_sel
);

`ifdef IMULDIV_DISPATCH_DIVZERO_EN
    localparam bit DIVZERO_EN = 1'b1;
`else
    localparam bit DIVZERO_EN = 1'b0;
`endif

    dispatch_state_e state_q, state_d;
    logic req_rdy_q, req_rdy_d;
    logic resp_val_q, resp_val_d;
    logic mul_req_val_q, mul_req_val_d;
    logic div_req_val_q, div_req_val_d;
    logic mul_resp_rdy_q, mul_resp_rdy_d;
    logic div_resp_rdy_q, div_resp_rdy_d;

    unit_e cur_unit, nxt_unit;
    logic  cur_bypass, nxt_bypass;

    assign accept = req_val & req_rdy_q;

    always_comb begin
        state_d     = state_q;
        load_result = 1'b0;
        result_sel  = RSEL_ZERO;
        cur_unit    = fn_unit(cur_fn);
        cur_bypass  = DIVZERO_EN && (cur_unit == UNIT_DIV) && cur_b_zero;

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (cur_unit == UNIT_MUL) begin
                    if (mul_req_rdy) state_d = ST_WAIT;
                end else if ((cur_unit == UNIT_DIV) && !cur_bypass) begin
                    if (div_req_rdy) state_d = ST_WAIT;
                end else begin
                    // Illegal function or divide-by-zero shortcut: answer without a sub-unit.
                    state_d     = ST_RESP;
                    load_result = 1'b1;
                    if (cur_bypass) result_sel = RSEL_DIVZERO;
                    else            result_sel = RSEL_ZERO;
                end
            end
            ST_WAIT: begin
                if ((cur_unit == UNIT_MUL) && mul_resp_val) begin
                    state_d     = ST_RESP;
                    load_result = 1'b1;
                    result_sel  = RSEL_MUL;
                end else if ((cur_unit == UNIT_DIV) && div_resp_val) begin
                    state_d     = ST_RESP;
                    load_result = 1'b1;
                    result_sel  = RSEL_DIV;
                end
            end
            ST_RESP: begin
                if (resp_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Leaving IDLE the fn/b registers are not loaded yet, so decode the incoming request.
        if (state_q == ST_IDLE) begin
            nxt_unit   = fn_unit(req_fn);
            nxt_bypass = DIVZERO_EN && (nxt_unit == UNIT_DIV) && req_b_zero;
        end else begin
            nxt_unit   = cur_unit;
            nxt_bypass = cur_bypass;
        end

        req_rdy_d      = (state_d == ST_IDLE);
        resp_val_d     = (state_d == ST_RESP);
        mul_req_val_d  = (state_d == ST_ISSUE) && (nxt_unit == UNIT_MUL);
        div_req_val_d  = (state_d == ST_ISSUE) && (nxt_unit == UNIT_DIV) && !nxt_bypass;
        mul_resp_rdy_d = (state_d == ST_WAIT)  && (nxt_unit == UNIT_MUL);
        div_resp_rdy_d = (state_d == ST_WAIT)  && (nxt_unit == UNIT_DIV);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            req_rdy_q      <= 1'b1;
            resp_val_q     <= 1'b0;
            mul_req_val_q  <= 1'b0;
            div_req_val_q  <= 1'b0;
            mul_resp_rdy_q <= 1'b0;
            div_resp_rdy_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_rdy_q      <= req_rdy_d;
            resp_val_q     <= resp_val_d;
            mul_req_val_q  <= mul_req_val_d;
            div_req_val_q  <= div_req_val_d;
            mul_resp_rdy_q <= mul_resp_rdy_d;
            div_resp_rdy_q <= div_resp_rdy_d;
        end
    end

    assign req_rdy      = req_rdy_q;
    assign resp_val     = resp_val_q;
    assign mul_req_val  = mul_req_val_q;
    assign div_req_val  = div_req_val_q;
    assign mul_resp_rdy = mul_resp_rdy_q;
    assign div_resp_rdy = div_resp_rdy_q;

endmodule

// File: rtl/imuldiv_muldiv_dispatch.sv
// Muldiv front end: routes one request to the multiplier or divider, returns its 64-bit result.
// Latency 2 + sub-unit issue wait + compute; RESP holds under backpressure. Option: IMULDIV_DISPATCH_DIVZERO_EN.
module imuldiv_muldiv_dispatch
    import imuldiv_muldiv_dispatch_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [FN_W-1:0]     muldivreq_msg_fn,
    input  logic [DATA_W-1:0]   muldivreq_msg_a,
    input  logic [DATA_W-1:0]   muldivreq_msg_b,
    input  logic                muldivreq_val,
    output logic                muldivreq_rdy,
    output logic [RESULT_W-1:0] muldivresp_msg_result,
    output logic                muldivresp_val,
    input  logic                muldivresp_rdy,
    output logic [DATA_W-1:0]   mulreq_msg_a,
    output logic [DATA_W-1:0]   mulreq_msg_b,
    output logic                mulreq_val,
    input  logic                mulreq_rdy,
    input  logic [RESULT_W-1:0] mulresp_msg_result,
    input  logic                mulresp_val,
    output logic                mulresp_rdy,
    output logic                divreq_msg_fn,
    output logic [DATA_W-1:0]   divreq_msg_a,
    output logic [DATA_W-1:0]   divreq_msg_b,
    output logic                divreq_val,
    input  logic                divreq_rdy,
    input  logic [RESULT_W-1:0] divresp_msg_result,
    input  logic                divresp_val,
    output logic                divresp_rdy
);

    logic [FN_W-1:0]     fn_q, fn_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [RESULT_W-1:0] result_q, result_d;

    logic        req_rdy;
    logic        accept;
    logic        load_result;
    result_sel_e result_sel;

    imuldiv_muldiv_dispatch_ctrl u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .req_val      (muldivreq_val),
        .req_fn       (muldivreq_msg_fn),
        .req_b_zero   (muldivreq_msg_b == '0),
        .cur_fn       (fn_q),
        .cur_b_zero   (b_q == '0),
        .mul_req_rdy  (mulreq_rdy),
        .div_req_rdy  (divreq_rdy),
        .mul_resp_val (mulresp_val),
        .div_resp_val (divresp_val),
        .resp_rdy     (muldivresp_rdy),
        .req_rdy      (req_rdy),
        .resp_val     (muldivresp_val),
        .mul_req_val  (mulreq_val),
        .div_req_val  (divreq_val),
        .mul_resp_rdy (mulresp_rdy),
        .div_resp_rdy (divresp_rdy),
        .accept       (accept),
        .load_result  (load_result),
        .result_sel   (result_sel)
    );

    always_comb begin
        fn_d     = fn_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        if (accept) begin
            fn_d = muldivreq_msg_fn;
            a_d  = muldivreq_msg_a;
            b_d  = muldivreq_msg_b;
        end
        if (load_result) begin
            case (result_sel)
                RSEL_MUL:     result_d = mulresp_msg_result;
                RSEL_DIV:     result_d = divresp_msg_result;
                RSEL_DIVZERO: result_d = {a_q, 32'hFFFF_FFFF};
                default:      result_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fn_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            fn_q     <= fn_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign muldivreq_rdy         = req_rdy;
    assign muldivresp_msg_result = result_q;
    assign mulreq_msg_a          = a_q;
    assign mulreq_msg_b          = b_q;
    assign divreq_msg_a          = a_q;
    assign divreq_msg_b          = b_q;
    // Signedness is only meaningful while a request is in flight; IDLE presents 0.
    assign divreq_msg_fn         = fn_is_signed(fn_q) & ~req_rdy;

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// Bench for the muldiv dispatch stage: directed cases plus random transactions against stub units.
`timescale 1ns/1ps
module tb_imuldiv_muldiv_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  muldivreq_msg_fn;
    logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
    logic        muldivreq_val, muldivreq_rdy;
    logic [63:0] muldivresp_msg_result;
    logic        muldivresp_val, muldivresp_rdy;
    logic [31:0] mulreq_msg_a, mulreq_msg_b;
    logic        mulreq_val, mulreq_rdy;
    logic [63:0] mulresp_msg_result;
    logic        mulresp_val, mulresp_rdy;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a, divreq_msg_b;
    logic        divreq_val, divreq_rdy;
    logic [63:0] divresp_msg_result;
    logic        divresp_val, divresp_rdy;

    always #5 clk = ~clk;

    imuldiv_muldiv_dispatch dut (
        .clk(clk), .reset(reset),
        .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
        .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
        .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
        .muldivresp_rdy(muldivresp_rdy),
        .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b), .mulreq_val(mulreq_val),
        .mulreq_rdy(mulreq_rdy), .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val),
        .mulresp_rdy(mulresp_rdy),
        .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy), .divresp_msg_result(divresp_msg_result),
        .divresp_val(divresp_val), .divresp_rdy(divresp_rdy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

`ifdef IMULDIV_DISPATCH_DIVZERO_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    // What the stub execution units compute; results are packed {hi/rem, lo/quot}.
    function automatic logic [63:0] unit_result(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     si, sj;
        logic [31:0] q, r;
        if (fn == 3'd0) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        if (b == 32'd0) return {32'hDEAD_BEEF, a};
        if (fn == 3'd1 || fn == 3'd3) begin
            si = $signed(a);
            sj = $signed(b);
            if (sj == -1) begin
                q = 32'(-si);
                r = 32'd0;
            end else begin
                q = 32'(si / sj);
                r = 32'(si % sj);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // 0 = no sub-unit involved, 1 = multiplier, 2 = divider
    function automatic int unit_of(input logic [2:0] fn, input logic [31:0] b);
        if (fn == 3'd0) return 1;
        if (fn >= 3'd1 && fn <= 3'd4) return (DZ && b == 32'd0) ? 0 : 2;
        return 0;
    endfunction

    function automatic logic [63:0] expected(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        if (fn > 3'd4) return 64'd0;
        if (unit_of(fn, b) == 0) return {a, 32'hFFFF_FFFF};
        return unit_result(fn, a, b);
    endfunction

    int cfg_w = 0;
    int cfg_d = 1;
    bit stray_en = 0;
    int mon_unit = 0;
    int viol = 0;
    int stray_ack = 0;

    // Multiplier stub: hold rdy low cfg_w cycles, respond cfg_d cycles after the handshake.
    int ms_st = 0, ms_cnt = 0, mul_hs = 0, mul_unstable = 0;
    logic [31:0] ms_a, ms_b;
    always @(negedge clk) begin
        if (reset) begin
            ms_st = 0; mulreq_rdy = 0; mulresp_val = 0; mulresp_msg_result = 0;
        end else begin
            case (ms_st)
                0: begin
                    mulresp_val = 0;
                    if (mulreq_val) begin
                        ms_a = mulreq_msg_a; ms_b = mulreq_msg_b; ms_cnt = cfg_w;
                        if (ms_cnt == 0) begin mulreq_rdy = 1; ms_st = 2; end
                        else ms_st = 1;
                    end else if (stray_en && $urandom_range(0, 5) == 0) begin
                        mulresp_val = 1;
                        mulresp_msg_result = {$urandom, $urandom};
                        if (mulresp_rdy) stray_ack++;
                    end
                end
                1: begin
                    if (!mulreq_val || mulreq_msg_a != ms_a || mulreq_msg_b != ms_b) mul_unstable++;
                    ms_cnt--;
                    if (ms_cnt == 0) begin mulreq_rdy = 1; ms_st = 2; end
                end
                2, 3: begin
                    if (ms_st == 2) begin mulreq_rdy = 0; mul_hs++; ms_cnt = cfg_d; end
                    ms_cnt--;
                    ms_st = 3;
                    if (ms_cnt == 0) begin
                        mulresp_val = 1;
                        mulresp_msg_result = unit_result(3'd0, ms_a, ms_b);
                        if (!mulresp_rdy) mul_unstable++;
                        ms_st = 4;
                    end
                end
                default: begin mulresp_val = 0; ms_st = 0; end
            endcase
        end
    end

    // Divider stub, same protocol.
    int ds_st = 0, ds_cnt = 0, div_hs = 0, div_unstable = 0;
    logic [31:0] ds_a, ds_b;
    logic        ds_fn;
    always @(negedge clk) begin
        if (reset) begin
            ds_st = 0; divreq_rdy = 0; divresp_val = 0; divresp_msg_result = 0;
        end else begin
            case (ds_st)
                0: begin
                    divresp_val = 0;
                    if (divreq_val) begin
                        ds_a = divreq_msg_a; ds_b = divreq_msg_b; ds_fn = divreq_msg_fn; ds_cnt = cfg_w;
                        if (ds_cnt == 0) begin divreq_rdy = 1; ds_st = 2; end
                        else ds_st = 1;
                    end else if (stray_en && $urandom_range(0, 5) == 0) begin
                        divresp_val = 1;
                        divresp_msg_result = {$urandom, $urandom};
                        if (divresp_rdy) stray_ack++;
                    end
                end
                1: begin
                    if (!divreq_val || divreq_msg_a != ds_a || divreq_msg_b != ds_b || divreq_msg_fn != ds_fn)
                        div_unstable++;
                    ds_cnt--;
                    if (ds_cnt == 0) begin divreq_rdy = 1; ds_st = 2; end
                end
                2, 3: begin
                    if (ds_st == 2) begin divreq_rdy = 0; div_hs++; ds_cnt = cfg_d; end
                    ds_cnt--;
                    ds_st = 3;
                    if (ds_cnt == 0) begin
                        divresp_val = 1;
                        divresp_msg_result = unit_result(ds_fn ? 3'd1 : 3'd2, ds_a, ds_b);
                        // Unsigned/signed divide share quotient path; remainder fn only changes the consumer's pick.
                        if (!divresp_rdy) div_unstable++;
                        ds_st = 4;
                    end
                end
                default: begin divresp_val = 0; ds_st = 0; end
            endcase
        end
    end

    // The unit not involved in the current transaction must never see val or resp_rdy.
    always @(negedge clk) begin
        if (!reset) begin
            if (mon_unit != 1 && (mulreq_val || mulresp_rdy)) viol++;
            if (mon_unit != 2 && (divreq_val || divresp_rdy)) viol++;
        end
    end

    task automatic run_txn(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                           input int w, input int d, input int bp);
        int u, lat, exp_lat, mh0, dh0, hold_err;
        logic [63:0] exp_r, held;
        u       = unit_of(fn, b);
        exp_r   = expected(fn, a, b);
        exp_lat = (u == 0) ? 2 : 2 + w + d;
        cfg_w = w; cfg_d = d;
        mh0 = mul_hs; dh0 = div_hs;
        mul_unstable = 0; div_unstable = 0; viol = 0; hold_err = 0;
        lat = 0;
        while (!muldivreq_rdy && lat < 50) begin @(negedge clk); lat++; end
        check("req_rdy_idle", 64'(muldivreq_rdy), 64'd1);
        mon_unit = u;
        muldivreq_val = 1; muldivreq_msg_fn = fn; muldivreq_msg_a = a; muldivreq_msg_b = b;
        @(negedge clk);
        muldivreq_val = 0;
        muldivreq_msg_fn = 3'($urandom); muldivreq_msg_a = $urandom; muldivreq_msg_b = $urandom;
        lat = 1;
        while (!muldivresp_val && lat < 200) begin
            if (muldivreq_rdy) viol++;
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("result", muldivresp_msg_result, exp_r);
        held = muldivresp_msg_result;
        for (int i = 0; i < bp; i++) begin
            if (muldivresp_msg_result !== held || !muldivresp_val || muldivreq_rdy) hold_err++;
            @(negedge clk);
        end
        check("resp_hold", 64'(hold_err), 64'd0);
        muldivresp_rdy = 1;
        @(negedge clk);
        muldivresp_rdy = 0;
        check("idle_after", {62'd0, muldivresp_val, muldivreq_rdy}, 64'd1);
        check("mul_issued", 64'(mul_hs - mh0), 64'(u == 1));
        check("div_issued", 64'(div_hs - dh0), 64'(u == 2));
        if (u == 1) check("mul_ops", {ms_a, ms_b}, {a, b});
        if (u == 2) begin
            check("div_ops", {ds_a, ds_b}, {a, b});
            check("div_fn", 64'(ds_fn), 64'(fn == 3'd1 || fn == 3'd3));
        end
        check("stable", 64'(mul_unstable + div_unstable), 64'd0);
        check("nonsel", 64'(viol), 64'd0);
        mon_unit = 0;
    endtask

    initial begin
        reset = 1; muldivreq_val = 0; muldivreq_msg_fn = 0; muldivreq_msg_a = 0; muldivreq_msg_b = 0;
        muldivresp_rdy = 0;
        repeat (3) @(negedge clk);
        check("rst_req_rdy", 64'(muldivreq_rdy), 64'd1);
        check("rst_resp_val", 64'(muldivresp_val), 64'd0);
        check("rst_sub_val", {62'd0, mulreq_val, divreq_val}, 64'd0);
        check("rst_sub_rdy", {62'd0, mulresp_rdy, divresp_rdy}, 64'd0);
        check("rst_div_fn", 64'(divreq_msg_fn), 64'd0);
        check("rst_result", muldivresp_msg_result, 64'd0);
        reset = 0;
        @(negedge clk);

        run_txn(3'd0, 32'd7, 32'd6, 0, 5, 0);                 // MUL: 42 seven cycles after accept
        run_txn(3'd1, 32'hFFFF_FFF9, 32'd2, 1, 3, 1);         // DIV -7/2 -> {-1, -3}
        run_txn(3'd4, 32'd10, 32'd3, 5, 2, 0);                // REMU with stalled divreq_rdy
        run_txn(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1, 0); // illegal fn
        run_txn(3'd0, 32'hFFFF_FFFF, 32'd3, 2, 2, 10);        // long response backpressure
        run_txn(3'd2, 32'd5, 32'd0, 0, 2, 2);                 // DIVU by zero
        check("div_m7_2", expected(3'd1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

        stray_en = 1;
        for (int t = 0; t < 60; t++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 9) : $urandom);
            run_txn(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 4), $urandom_range(1, 6), $urandom_range(0, 3));
        end
        stray_en = 0;
        repeat (2) @(negedge clk);
        check("stray_ignored", 64'(stray_ack), 64'd0);

        // Reset while a divide is stuck in ISSUE: the request is abandoned.
        cfg_w = 8; cfg_d = 2; mon_unit = 2;
        muldivreq_val = 1; muldivreq_msg_fn = 3'd1; muldivreq_msg_a = 32'd100; muldivreq_msg_b = 32'd7;
        @(negedge clk);
        muldivreq_val = 0;
        repeat (2) @(negedge clk);
        check("mid_div_val", 64'(divreq_val), 64'd1);
        #1 reset = 1;
        @(negedge clk);
        #1 reset = 0;
        mon_unit = 0;
        check("mid_rst_rdy", {62'd0, muldivreq_rdy, divreq_val}, 64'd2);
        @(negedge clk);
        run_txn(3'd3, 32'd100, 32'd7, 1, 1, 0);              // REM after recovery -> {2, 14}

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
